// File: rtl/inv_sbox_lookup.sv
// inv_sbox_lookup
//
// This block builds an inverse S-box from the forward S-box load stream and
// then answers inverse-substitution lookups.
//
// LOAD mode:
//   The block receives the forward table in index order, one entry per
//   load_en beat, and writes inv[load_data] = index.
//   After LOAD_COUNT beats it moves to SERVE mode.
//
// SERVE mode:
//   Each accepted lookup returns inv[in_data] one cycle later through a
//   registered output.
//
// Handshake (both sides):
//   A beat transfers on a rising edge where valid && ready.
//   The source holds valid and data stable until it sees ready.
//   The sink's ready does not depend on valid.
//
// Optional build macro INV_SBOX_DUPCHK_EN:
//   Tracks which S-box values have already been loaded.
//   Latches dup_err when a value is loaded twice.
//   Without the macro, dup_err is tied low.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous restart into LOAD (the table is kept)
//   load_en    load beat strobe
//   load_data  forward S-box value for the current index
//   load_done  high while in SERVE mode (registered)
//   in_valid   lookup request valid
//   in_data    byte to inverse-substitute
//   in_ready   lookup request can be accepted
//   out_valid  result valid
//   out_data   inverse-substituted byte
//   out_ready  downstream accepts the result
//   dup_err    duplicate S-box value seen during load
module inv_sbox_lookup #(
  parameter int DATA_W     = 8,
  parameter int LOAD_COUNT = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load_en,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_done,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              dup_err
);

  localparam int DEPTH = 1 << DATA_W;
  localparam logic [DATA_W:0] LAST_IDX = (DATA_W+1)'(LOAD_COUNT - 1);

  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W:0]   idx;
  logic [DATA_W:0]   idx_nxt;
  logic              load_done_nxt;
  logic              write_en;
  logic              accept;

  logic [DATA_W-1:0] inv_tbl [DEPTH];

  // A load beat only counts in LOAD mode.
  // A clear in the same cycle overrides it.
  assign write_en = (state == ST_LOAD) && load_en && !clear;

  // Ready depends only on registered state, clear and out_ready.
  // It never depends on in_valid.
  assign in_ready = (state == ST_SERVE) && !clear && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_LOAD;
      idx       <= '0;
      load_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      load_done <= load_done_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and load index
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    load_done_nxt = load_done;
    if (clear) begin
      state_nxt     = ST_LOAD;
      idx_nxt       = '0;
      load_done_nxt = 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (load_en) begin
            idx_nxt = idx + 1'b1;
            if (idx == LAST_IDX) begin
              state_nxt     = ST_SERVE;
              load_done_nxt = 1'b1;
            end
          end
        end
        ST_SERVE: begin
          // In SERVE mode load_en is ignored.
          // The state holds until clear or reset.
          state_nxt = ST_SERVE;
        end
        default: begin
          state_nxt = ST_LOAD;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Inverse table
  //   Writes happen only in LOAD mode.
  //   Reads are used only in SERVE mode, so reads and writes never collide.
  //   A duplicate load value overwrites its entry (last write wins).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        inv_tbl[i] <= '0;
      end
    end else if (write_en) begin
      inv_tbl[load_data] <= idx[DATA_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Registered lookup output
  //   clear drops any pending result.
  //   out_data keeps its last value because it only matters while out_valid.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= inv_tbl[in_data];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Duplicate detection
  // ---------------------------------------------------------------------------
`ifdef INV_SBOX_DUPCHK_EN
  logic [DEPTH-1:0] seen;
  logic             dup_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen      <= '0;
      dup_err_q <= 1'b0;
    end else if (clear) begin
      seen      <= '0;
      dup_err_q <= 1'b0;
    end else if (write_en) begin
      seen[load_data] <= 1'b1;
      if (seen[load_data]) begin
        dup_err_q <= 1'b1;
      end
    end
  end

  assign dup_err = dup_err_q;
`else
  assign dup_err = 1'b0;
`endif

endmodule

// File: tb/tb_inv_sbox_lookup.sv
// Testbench for inv_sbox_lookup.
//
// A cycle-level reference model (an inverse array plus a load index) is kept
// on the falling edge.
// Accepted lookups push the expected byte into exp_q.
// Output transfers pop exp_q and compare against the DUT.
module tb_inv_sbox_lookup;

  localparam int DATA_W     = 8;
  localparam int LOAD_COUNT = 256;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT signals
  // ---------------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear;
  logic              load_en;
  logic [DATA_W-1:0] load_data;
  logic              load_done;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              dup_err;

  always #5 clk = ~clk;

  inv_sbox_lookup #(
    .DATA_W     (DATA_W),
    .LOAD_COUNT (LOAD_COUNT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .load_en   (load_en),
    .load_data (load_data),
    .load_done (load_done),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .dup_err   (dup_err)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] ref_inv [256];
  bit                seen_m  [256];
  int                m_idx;
  bit                m_serve;
  bit                m_dup;
  int                n_checks = 0;
  int                n_fail   = 0;
  logic [DATA_W-1:0] load_vals [256];
  bit                rand_rdy = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      ref_inv[i] = '0;
      seen_m[i]  = 1'b0;
    end
    m_idx   = 0;
    m_serve = 0;
    m_dup   = 0;
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  //   First compare the DUT against the model.
  //   Then advance the model by what the coming rising edge will do.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    bit acc;
    bit q_busy;
    if (!rst_n) begin
      model_reset();
      chk("rst_load_done", load_done, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data",  out_data,  0);
      chk("rst_in_ready",  in_ready,  0);
      chk("rst_dup_err",   dup_err,   0);
    end else begin
      q_busy = (exp_q.size() != 0);
      chk("load_done", load_done, m_serve);
      chk("in_ready",  in_ready,  m_serve && !clear && (!q_busy || out_ready));
      chk("out_valid", out_valid, q_busy);
      if (q_busy) chk("out_data", out_data, exp_q[0]);
      chk("dup_err", dup_err, m_dup);

      if (clear) begin
        m_serve = 0;
        m_idx   = 0;
        m_dup   = 0;
        exp_q.delete();
        for (int i = 0; i < 256; i++) seen_m[i] = 1'b0;
      end else begin
        acc = in_valid && m_serve && (!q_busy || out_ready);
        if (!m_serve && load_en) begin
`ifdef INV_SBOX_DUPCHK_EN
          if (seen_m[load_data]) m_dup = 1;
`endif
          seen_m[load_data]  = 1'b1;
          ref_inv[load_data] = m_idx[DATA_W-1:0];
          m_idx++;
          if (m_idx == LOAD_COUNT) m_serve = 1;
        end
        if (q_busy && out_ready) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(ref_inv[in_data]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int n);
    for (int i = 0; i < n; i++) begin
      load_en   = 1'b1;
      load_data = load_vals[i];
      step();
    end
    load_en = 1'b0;
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    bit acc;
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      @(negedge clk);
      acc = in_ready;
      step();
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      if (acc) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (3) step();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    load_en   = 1'b0;
    load_data = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Identity load, then lookups (in_valid during LOAD must be held off)
    for (int i = 0; i < 256; i++) load_vals[i] = 8'(i);
    in_valid = 1'b1;
    in_data  = 8'h11;
    do_load(LOAD_COUNT);
    in_valid = 1'b0;
    send(8'h00);
    send(8'h7F);
    send(8'hFF);
    drain();

    // Reversal load with back-to-back lookups
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 256; i++) load_vals[i] = 8'(255 - i);
    do_load(LOAD_COUNT);
    send(8'h00);
    send(8'h10);
    for (int i = 0; i < 20; i++) send(8'($urandom_range(0, 255)));
    drain();

    // Backpressure: the result must stay fixed while out_ready is low
    out_ready = 1'b0;
    send(8'h42);
    in_valid = 1'b1;
    in_data  = 8'h24;
    repeat (5) step();
    out_ready = 1'b1;
    send(8'h24);
    drain();

    // A load beat in SERVE must leave the table unchanged
    load_en   = 1'b1;
    load_data = 8'h3C;
    step();
    load_en = 1'b0;
    send(8'h3C);
    send(8'h00);
    drain();

    // Clear while a result is pending
    out_ready = 1'b0;
    send(8'h55);
    clear = 1'b1;
    step();
    clear     = 1'b0;
    out_ready = 1'b1;
    step();

    // Partial load followed by an asynchronous reset
    for (int i = 0; i < 256; i++) load_vals[i] = 8'($urandom_range(0, 255));
    do_load(100);
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Random load with duplicates; index 3 and index 9 both carry 0x05.
    // Entries that are not hit must read back 0.
    for (int i = 0; i < 256; i++) begin
      load_vals[i] = 8'($urandom_range(0, 255));
      if (i > 9 && load_vals[i] == 8'h05) load_vals[i] = 8'h06;
      if (i < 9 && i != 3 && load_vals[i] == 8'h05) load_vals[i] = 8'h07;
    end
    load_vals[3] = 8'h05;
    load_vals[9] = 8'h05;
    do_load(LOAD_COUNT);
    rand_rdy = 1;
    send(8'h05);
    for (int i = 0; i < 256; i++) send(8'(i));
    rand_rdy = 0;
    drain();

    // clear resets dup_err and load_done
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
